// File: rtl/spi_boot_pkg.sv
// Shared types and constants for the SPI boot hand-off sequencer.
package spi_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WAKE,
        GAP,
        PROG,
        DONE
    } boot_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_HIGH,
        TX_LOW
    } tx_phase_e;

    localparam logic [7:0] WAKE_CMD_DEFAULT = 8'hAB;

endpackage

// File: rtl/spi_boot_sequencer_spi_byte_tx.sv
// Mode-0, MSB-first single-byte SPI transmitter with a one-cycle CS setup
// ahead of the first SCK rise and a one-cycle done pulse after CS releases.
module spi_byte_tx
    import spi_boot_pkg::*;
#(
    parameter int SCK_DIV = 2
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       cs,
    output logic       sck,
    output logic       mosi
);

    localparam int DIV_W = $clog2(SCK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCK_DIV);
    localparam logic [3:0] BIT_TC = 4'd8;

    tx_phase_e        phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d, div_nxt;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             done_q, done_d;

    always_comb begin
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        done_d  = 1'b0;
        div_nxt = div_q + DIV_W'(1);
        case (phase_q)
            TX_IDLE: begin
                if (start) begin
                    phase_d = TX_SETUP;
                    cs_d    = 1'b0;
                    sh_d    = data;
                    bit_d   = '0;
                    div_d   = '0;
                end
            end
            TX_SETUP: begin
                phase_d = TX_HIGH;
                sck_d   = 1'b1;
                div_d   = '0;
            end
            TX_HIGH: begin
                // MOSI advances on the falling edge so it is stable across the next rise.
                if (div_nxt == DIV_TC) begin
                    phase_d = TX_LOW;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    sh_d    = {sh_q[6:0], 1'b0};
                    bit_d   = bit_q + 4'd1;
                end else begin
                    div_d = div_nxt;
                end
            end
            TX_LOW: begin
                if (div_nxt == DIV_TC) begin
                    div_d = '0;
                    if (bit_q == BIT_TC) begin
                        phase_d = TX_IDLE;
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = TX_HIGH;
                        sck_d   = 1'b1;
                    end
                end else begin
                    div_d = div_nxt;
                end
            end
            default: phase_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign cs   = cs_q;
    assign sck  = sck_q;
    assign mosi = sh_q[7];

endmodule

// File: rtl/spi_boot_sequencer.sv
// Hands the flash bus from the bootloader to an internal wake-up shifter,
// then pulses PROGRAMN to reconfigure the ECP5 into the user image.
//
// state | meaning
// IDLE  | passthrough, waiting for boot_req
// DRAIN | passthrough, waiting for CS_IDLE_CYCLES consecutive CS-high cycles
// WAKE  | bus owned, shifter sends WAKE_CMD
// GAP   | CS held high for flash recovery
// PROG  | PROGRAMN driven low for PROGRAMN_CYCLES
// DONE  | terminal, bus still owned, PROGRAMN released
module spi_boot_sequencer
    import spi_boot_pkg::*;
#(
    parameter int         PROGRAMN_CYCLES = 256,
    parameter int         CS_IDLE_CYCLES  = 16,
    parameter int         SCK_DIV         = 2,
    parameter logic [7:0] WAKE_CMD        = WAKE_CMD_DEFAULT
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic boot_req,
    input  logic bl_spi_cs,
    input  logic bl_spi_sck,
    input  logic bl_spi_mosi,
    output logic bl_spi_miso,
    output logic spi_cs,
    output logic spi_sck,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic programn,
    output logic busy
);

    localparam int IDLE_W = $clog2(CS_IDLE_CYCLES + 1);
    localparam int PROG_W = $clog2(PROGRAMN_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(CS_IDLE_CYCLES);
    localparam logic [PROG_W-1:0] PROG_TC = PROG_W'(PROGRAMN_CYCLES);

    boot_state_e       state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_nxt;
    logic [PROG_W-1:0] prog_cnt_q, prog_cnt_d, prog_nxt;
    logic              own_q, own_d;
    logic              programn_q, programn_d;
    logic              busy_q, busy_d;
    logic              tx_start;
    logic              tx_done, tx_cs, tx_sck, tx_mosi;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        prog_cnt_d = prog_cnt_q;
        own_d      = own_q;
        programn_d = programn_q;
        tx_start   = 1'b0;
        idle_nxt   = idle_cnt_q + IDLE_W'(1);
        prog_nxt   = prog_cnt_q + PROG_W'(1);
        case (state_q)
            IDLE: begin
                if (boot_req) begin
                    state_d    = DRAIN;
                    idle_cnt_d = '0;
                end
            end
            DRAIN: begin
                // Shifter starts on the same edge ownership flips, so CS drops with own.
                if (!bl_spi_cs) begin
                    idle_cnt_d = '0;
                end else if (idle_nxt == IDLE_TC) begin
                    idle_cnt_d = '0;
                    own_d      = 1'b1;
                    tx_start   = 1'b1;
                    state_d    = WAKE;
                end else begin
                    idle_cnt_d = idle_nxt;
                end
            end
            WAKE: begin
                if (tx_done) begin
                    state_d    = GAP;
                    idle_cnt_d = '0;
                end
            end
            GAP: begin
                if (idle_nxt == IDLE_TC) begin
                    idle_cnt_d = '0;
                    prog_cnt_d = '0;
                    programn_d = 1'b0;
                    state_d    = PROG;
                end else begin
                    idle_cnt_d = idle_nxt;
                end
            end
            PROG: begin
                if (prog_nxt == PROG_TC) begin
                    programn_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    prog_cnt_d = prog_nxt;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            prog_cnt_q <= '0;
            own_q      <= 1'b0;
            programn_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            prog_cnt_q <= prog_cnt_d;
            own_q      <= own_d;
            programn_q <= programn_d;
            busy_q     <= busy_d;
        end
    end

    spi_byte_tx #(
        .SCK_DIV(SCK_DIV)
    ) u_tx (
        .clk_48mhz(clk_48mhz),
        .reset_n  (reset_n),
        .start    (tx_start),
        .data     (WAKE_CMD),
        .done     (tx_done),
        .cs       (tx_cs),
        .sck      (tx_sck),
        .mosi     (tx_mosi)
    );

    assign spi_cs      = own_q ? tx_cs   : bl_spi_cs;
    assign spi_sck     = own_q ? tx_sck  : bl_spi_sck;
    assign spi_mosi    = own_q ? tx_mosi : bl_spi_mosi;
    assign bl_spi_miso = spi_miso;
    assign programn    = programn_q;
    assign busy        = busy_q;

endmodule
